// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFO read/write schedulers.
package fifo_arb_pkg;

    // Scheduler FSM: waiting for a request, or serving one burst.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of a requester index; keeps a 1-bit index when only one requester exists.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Burst length actually served: a zero length still moves one word,
    // and anything longer than the largest supported burst is cut down to it.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_burst);
        if (len == 0)
            return 1;
        else if (len > max_burst)
            return max_burst;
        else
            return len;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// Rotate-priority selector: picks the first asserted request after ptr, wrapping around.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] sel_oh,
    output logic [ID_W-1:0]    sel_idx,
    output logic               any
);

    int idx;

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
        sel_oh  = '0;
        sel_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any     = 1'b1;
                sel_idx = ID_W'(idx);
                sel_oh  = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler: shares one FWFT FIFO read port among NUM_REQ consumers
// with round-robin grants and per-requester burst lengths.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int BURST_W    = $clog2(MAX_BURST + 1),
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BURST_W-1:0] req_len,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rd_inc,
    input  logic                       rd_empty,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [ID_W-1:0]            out_id,
    output logic                       out_last,
    output logic                       abort,
    output logic                       busy
);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]        sel_q, sel_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [BURST_W-1:0]     cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [ID_W-1:0]        out_id_q, out_id_d;
    logic                   out_last_q, out_last_d;
    logic                   abort_q, abort_d;

    logic [NUM_REQ-1:0]     arb_oh;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;
    logic [BURST_W-1:0]     arb_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .sel_oh  (arb_oh),
        .sel_idx (arb_idx),
        .any     (arb_any)
    );

    assign arb_len = req_len[arb_idx*BURST_W +: BURST_W];

    // Pop only while the granted owner still asks, data is present and words remain;
    // reset suppresses the pop in the cycle it is asserted.
    assign rd_inc = (state_q == BURST) && !rd_rst && !rd_empty && req[sel_q] && (cnt_q != '0);

    // Next-state and registered-output computation for the burst FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = BURST;
                    gnt_d   = arb_oh;
                    sel_d   = arb_idx;
                    cnt_d   = BURST_W'(clamp_len(32'(arb_len), MAX_BURST));
                end
            end
            BURST: begin
                if (!req[sel_q]) begin
                    // Owner withdrew: end early, no pop this cycle.
                    abort_d = 1'b1;
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                end else if (rd_inc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_id_d    = sel_q;
                    cnt_d       = cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) begin
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                        gnt_d      = '0;
                        ptr_d      = sel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; pointer starts so requester 0 wins first.
    always_ff @(posedge rd_clk) begin
        // NOTE: flops are written with non-blocking assignments so every register samples pre-edge values.
        if (rd_rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            abort_q     <= abort_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign abort     = abort_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: FIFO model, scheduler reference model,
// directed sequences, a length table and randomized traffic.
module tb_fifo_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int BW = 4;
    localparam int IW = 2;

    logic            rd_clk;
    logic            rd_rst;
    logic [N-1:0]    req;
    logic [N*BW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic            rd_inc;
    logic            rd_empty;
    logic [DW-1:0]   rd_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_last;
    logic            abort;
    logic            busy;

    fifo_rd_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .BURST_W    (BW)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .rd_inc    (rd_inc),
        .rd_empty  (rd_empty),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .abort     (abort),
        .busy      (busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO contents and observed output stream
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] lg_data[$];
    int            lg_id[$];
    int            lg_last[$];
    int            abort_cnt;
    int            stall_cnt;
    bit            auto_drop;

    // Reference model: current owner (-1 = none), words left, last served requester
    int            m_owner;
    int            m_rem;
    int            m_last;
    bit            e_valid, e_last, e_abort;
    logic [DW-1:0] e_data;
    int            e_id;

    typedef struct {
        int len;
        int exp_pops;
    } len_vec_t;
    len_vec_t len_tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_clamp(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    // One clock cycle: present FIFO head, check the pop decision mid-cycle,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle();
        logic [DW-1:0] d;
        logic [N-1:0]  eg;
        bit            exp_inc;
        int            pick;
        rd_empty = (fifo_q.size() == 0);
        rd_data  = rd_empty ? '0 : fifo_q[0];
        d        = rd_data;
        #2;
        exp_inc = (m_owner >= 0) && !rd_rst && !rd_empty && req[m_owner] && (m_rem > 0);
        eg      = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("rd_inc", 32'(rd_inc), 32'(exp_inc));
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        if (busy && rd_empty && !rd_inc) stall_cnt++;
        if (rd_inc && fifo_q.size() > 0) void'(fifo_q.pop_front());

        e_valid = 1'b0;
        e_last  = 1'b0;
        e_abort = 1'b0;
        if (rd_rst) begin
            m_owner = -1;
            m_rem   = 0;
            m_last  = N - 1;
            e_data  = '0;
            e_id    = 0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
            if (pick >= 0) begin
                m_owner = pick;
                m_rem   = m_clamp(int'(req_len[pick*BW +: BW]));
            end
        end else if (!req[m_owner]) begin
            e_abort = 1'b1;
            m_last  = m_owner;
            m_owner = -1;
        end else if (exp_inc) begin
            e_valid = 1'b1;
            e_data  = d;
            e_id    = m_owner;
            m_rem   = m_rem - 1;
            if (m_rem == 0) begin
                e_last  = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
            end
        end

        @(posedge rd_clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("out_last", 32'(out_last), 32'(e_last));
        check("abort", 32'(abort), 32'(e_abort));
        check("out_id", 32'(out_id), 32'(e_id));
        check("out_data", 32'(out_data), 32'(e_data));
        if (out_valid) begin
            lg_data.push_back(out_data);
            lg_id.push_back(int'(out_id));
            lg_last.push_back(int'(out_last));
        end
        if (abort) abort_cnt++;
        if (auto_drop && out_last) req[out_id] = 1'b0;
    endtask

    task automatic clear_logs();
        lg_data.delete();
        lg_id.delete();
        lg_last.delete();
        abort_cnt = 0;
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        req    = '0;
        rd_rst = 1'b1;
        cycle();
        rd_rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        logic [DW-1:0] ed[5];
        int            eid[5];
        int            elast[5];
        int            nlast;
        bit            dropped;

        len_tbl[0] = '{len: 0,  exp_pops: 1};
        len_tbl[1] = '{len: 1,  exp_pops: 1};
        len_tbl[2] = '{len: 3,  exp_pops: 3};
        len_tbl[3] = '{len: 8,  exp_pops: 8};
        len_tbl[4] = '{len: 9,  exp_pops: 8};
        len_tbl[5] = '{len: 15, exp_pops: 8};

        rd_rst    = 1'b1;
        req       = '0;
        req_len   = '0;
        rd_empty  = 1'b1;
        rd_data   = '0;
        auto_drop = 1'b1;
        clear_logs();
        repeat (2) @(posedge rd_clk);
        #1;
        // Reset state
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rd_inc", 32'(rd_inc), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_id", 32'(out_id), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_abort", 32'(abort), 32'(0));
        m_owner = -1; m_rem = 0; m_last = N - 1;
        e_data = '0; e_id = 0;
        rd_rst = 1'b0;

        // Two requesters, bursts of 3 and 2
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(8'h10 + i));
        req_len = '0;
        req_len[0*BW +: BW] = 4'd3;
        req_len[2*BW +: BW] = 4'd2;
        req = 4'b0101;
        repeat (10) cycle();
        ed    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        eid   = '{0, 0, 0, 2, 2};
        elast = '{0, 0, 1, 0, 1};
        check("t1_count", 32'(lg_data.size()), 32'(5));
        for (int i = 0; i < 5 && i < lg_data.size(); i++) begin
            check("t1_data", 32'(lg_data[i]), 32'(ed[i]));
            check("t1_id", 32'(lg_id[i]), 32'(eid[i]));
            check("t1_last", 32'(lg_last[i]), 32'(elast[i]));
        end

        // Continuous requests of length 1 rotate fairly
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(8'h40 + i));
        req_len = 16'h1111;
        req = 4'b1111;
        repeat (20) cycle();
        check("t2_count", 32'(lg_id.size() >= 8), 32'(1));
        for (int i = 0; i < 8 && i < lg_id.size(); i++)
            check("t2_rotate_id", 32'(lg_id[i]), 32'(i % N));
        auto_drop = 1'b1;

        // Empty stall mid-burst
        do_reset();
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        req_len = '0;
        req_len[0*BW +: BW] = 4'd4;
        req = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            if (c == 5) begin
                fifo_q.push_back(8'hA2);
                fifo_q.push_back(8'hA3);
            end
            cycle();
        end
        check("t3_count", 32'(lg_data.size()), 32'(4));
        check("t3_stall_seen", 32'(stall_cnt > 0), 32'(1));
        for (int i = 0; i < 4 && i < lg_data.size(); i++) begin
            check("t3_data", 32'(lg_data[i]), 32'(8'hA0 + i));
            check("t3_last", 32'(lg_last[i]), 32'(i == 3));
        end

        // Abort after two pops, then requester 1 is served
        do_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(8'h30 + i));
        req_len = '0;
        req_len[0*BW +: BW] = 4'd5;
        req_len[1*BW +: BW] = 4'd1;
        req = 4'b0011;
        dropped = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (!dropped && lg_data.size() == 2) begin
                req[0]  = 1'b0;
                dropped = 1'b1;
            end
        end
        check("t4_abort_cnt", 32'(abort_cnt), 32'(1));
        check("t4_count", 32'(lg_data.size()), 32'(3));
        ed    = '{8'h30, 8'h31, 8'h32, 8'h00, 8'h00};
        eid   = '{0, 0, 1, 0, 0};
        elast = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 3 && i < lg_data.size(); i++) begin
            check("t4_data", 32'(lg_data[i]), 32'(ed[i]));
            check("t4_id", 32'(lg_id[i]), 32'(eid[i]));
            check("t4_last", 32'(lg_last[i]), 32'(elast[i]));
        end

        // Burst length edges from the table
        foreach (len_tbl[t]) begin
            do_reset();
            for (int i = 0; i < 20; i++) fifo_q.push_back(DW'(i));
            req_len = '0;
            req_len[0*BW +: BW] = BW'(len_tbl[t].len);
            req = 4'b0001;
            repeat (14) cycle();
            check("t5_pops", 32'(lg_data.size()), 32'(len_tbl[t].exp_pops));
            nlast = 0;
            foreach (lg_last[i]) nlast += lg_last[i];
            check("t5_last_cnt", 32'(nlast), 32'(1));
            if (lg_last.size() > 0)
                check("t5_last_final", 32'(lg_last[lg_last.size()-1]), 32'(1));
        end

        // Reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(8'h60 + i));
        req_len = 16'h4441;
        req = 4'b0010;
        repeat (4) cycle();
        req = 4'b0100;
        repeat (3) cycle();
        req = 4'b1111;
        rd_rst = 1'b1;
        cycle();
        check("t6_gnt", 32'(gnt), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_rd_inc", 32'(rd_inc), 32'(0));
        check("t6_out_valid", 32'(out_valid), 32'(0));
        rd_rst = 1'b0;
        clear_logs();
        auto_drop = 1'b0;
        req_len = 16'h1111;
        repeat (3) cycle();
        check("t6_count", 32'(lg_id.size() > 0), 32'(1));
        if (lg_id.size() > 0) check("t6_first_id", 32'(lg_id[0]), 32'(0));
        auto_drop = 1'b1;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16)
                fifo_q.push_back(DW'($urandom));
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    req_len[i*BW +: BW] = BW'($urandom_range(0, 15));
                end else if (req[i] && $urandom_range(0, 40) == 0) begin
                    req[i] = 1'b0;
                end
            end
            rd_rst = ($urandom_range(0, 150) == 0);
            cycle();
        end
        rd_rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
